// File: rtl/fifo_wr_arb.sv
// Round-robin arbiter that merges NUM_REQ beat streams onto one FIFO write port.
// Each grant may write up to MAX_BURST beats; it stalls while full and never overflows.

module fifo_wr_arb_lane #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  i_gnt,
  input  logic                  i_wr_ok,
  input  logic [DATA_WIDTH-1:0] i_data,
  output logic                  o_ack,
  output logic [DATA_WIDTH-1:0] o_data
);
  // Non-owners contribute zero so the top can OR-merge all lanes.
  assign o_ack  = i_gnt & i_wr_ok;
  assign o_data = i_gnt ? i_data : '0;
endmodule

module fifo_wr_arb #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 4
) (
  input  logic                          wr_clk,
  input  logic                          rstn,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic                          full,
  output logic [NUM_REQ-1:0]            req_ack,
  output logic [NUM_REQ-1:0]            grant,
  output logic                          fifo_wr_en,
  output logic [DATA_WIDTH-1:0]         fifo_wr_data,
  output logic [15:0]                   wr_count
);
  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_BURST = 2'd1;
  localparam logic [1:0] ST_STALL = 2'd2;
  localparam logic [3:0] LAST_BEAT = 4'(MAX_BURST - 1);

  logic [1:0]         r_state;
  logic [NUM_REQ-1:0] r_grant;
  logic [IW-1:0]      r_rr_ptr;
  logic [3:0]         r_beat_cnt;
  logic [15:0]        r_wr_count;

  logic [1:0]         w_nxt_state;
  logic [NUM_REQ-1:0] w_nxt_grant;
  logic [IW-1:0]      w_nxt_ptr;
  logic [3:0]         w_nxt_beat;
  logic               w_release;

  logic [IW-1:0]      w_win;
  logic               w_any;
  logic [IW:0]        w_sum;
  logic [IW:0]        w_inc;
  logic [IW-1:0]      w_win_nxt;
  logic [NUM_REQ-1:0] w_win_oh;

  logic                                 w_gvalid;
  logic                                 w_wr_ok;
  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]   w_lane_data;
  logic [DATA_WIDTH-1:0]                w_data;

  // Walk offsets high to low so the nearest valid index from rr_ptr wins last.
  always_comb begin
    w_win = '0;
    w_any = 1'b0;
    w_sum = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      w_sum = {1'b0, r_rr_ptr} + (IW+1)'(k);
      if (w_sum >= (IW+1)'(NUM_REQ)) w_sum = w_sum - (IW+1)'(NUM_REQ);
      if (req_valid[w_sum[IW-1:0]]) begin
        w_win = w_sum[IW-1:0];
        w_any = 1'b1;
      end
    end
  end

  always_comb begin
    w_inc = {1'b0, w_win} + (IW+1)'(1);
    w_win_nxt = (w_inc == (IW+1)'(NUM_REQ)) ? '0 : w_inc[IW-1:0];
    w_win_oh = '0;
    w_win_oh[w_win] = 1'b1;
  end

  assign w_gvalid = |(r_grant & req_valid);
  assign w_wr_ok  = (r_state == ST_BURST) & w_gvalid & ~full;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_lane
    fifo_wr_arb_lane #(.DATA_WIDTH(DATA_WIDTH)) u_lane (
      .i_gnt   (r_grant[i]),
      .i_wr_ok (w_wr_ok),
      .i_data  (req_data[i*DATA_WIDTH +: DATA_WIDTH]),
      .o_ack   (req_ack[i]),
      .o_data  (w_lane_data[i])
    );
  end

  always_comb begin
    w_data = '0;
    for (int i = 0; i < NUM_REQ; i++) w_data = w_data | w_lane_data[i];
  end

  // IDLE is treated as a permanent release so re-arbitration shares one path.
  always_comb begin
    w_nxt_state = r_state;
    w_nxt_grant = r_grant;
    w_nxt_ptr   = r_rr_ptr;
    w_nxt_beat  = r_beat_cnt;
    w_release   = 1'b0;
    case (r_state)
      ST_IDLE: w_release = 1'b1;
      ST_BURST: begin
        if (!w_gvalid)                    w_release = 1'b1;
        else if (full)                    w_nxt_state = ST_STALL;
        else if (r_beat_cnt == LAST_BEAT) w_release = 1'b1;
        else                              w_nxt_beat = r_beat_cnt + 4'd1;
      end
      ST_STALL: begin
        if (!w_gvalid)  w_release = 1'b1;
        else if (!full) w_nxt_state = ST_BURST;
      end
      default: w_release = 1'b1;
    endcase
    if (w_release) begin
      w_nxt_beat = 4'd0;
      if (w_any && !full) begin
        w_nxt_state = ST_BURST;
        w_nxt_grant = w_win_oh;
        w_nxt_ptr   = w_win_nxt;
      end else begin
        w_nxt_state = ST_IDLE;
        w_nxt_grant = '0;
      end
    end
  end

  always_ff @(posedge wr_clk or negedge rstn) begin
    if (!rstn) begin
      r_state    <= ST_IDLE;
      r_grant    <= '0;
      r_rr_ptr   <= '0;
      r_beat_cnt <= 4'd0;
      r_wr_count <= 16'd0;
    end else begin
      r_state    <= w_nxt_state;
      r_grant    <= w_nxt_grant;
      r_rr_ptr   <= w_nxt_ptr;
      r_beat_cnt <= w_nxt_beat;
      if (w_wr_ok) r_wr_count <= r_wr_count + 16'd1;
    end
  end

  assign grant        = r_grant;
  assign fifo_wr_en   = w_wr_ok;
  assign fifo_wr_data = w_data;
  assign wr_count     = r_wr_count;
endmodule

// File: doc/fifo_wr_arb.md
FIFO_WR_ARB -- requirements
Module: fifo_wr_arb

Interface
REQ-001 Parameter NUM_REQ, default 4, SHALL set the number of write requesters (2..8).
REQ-002 Parameter DATA_WIDTH, default 8, SHALL set the data width of each requester and of the FIFO write port.
REQ-003 Parameter MAX_BURST, default 4, SHALL set the maximum beats one grant may write before rotation (1..15).
REQ-004 wr_clk  in  1  SHALL be the single clock; all state updates on its rising edge.
REQ-005 rstn  in  1  SHALL be the asynchronous, active-low reset.
REQ-006 req_valid  in  NUM_REQ  SHALL flag that requester i holds a beat to write.
REQ-007 req_data  in  NUM_REQ*DATA_WIDTH  SHALL carry requester i's beat in slice [i*DATA_WIDTH +: DATA_WIDTH].
REQ-008 full  in  1  SHALL be the FIFO write-side full flag.
REQ-009 req_ack  out  NUM_REQ  SHALL pulse for one cycle when requester i's beat is written.
REQ-010 grant  out  NUM_REQ  SHALL be the registered one-hot current owner; all zero when none.
REQ-011 fifo_wr_en  out  1  SHALL drive the FIFO write enable.
REQ-012 fifo_wr_data  out  DATA_WIDTH  SHALL drive the FIFO write data.
REQ-013 wr_count  out  16  SHALL count total beats written, wrapping at 65535->0.

Function
REQ-014 FSM states SHALL be IDLE (no owner), BURST (owner, writing), STALL (owner, full=1).
REQ-015 IDLE: if any req_valid and full=0, the next edge SHALL load grant with the round-robin winner and enter BURST; otherwise stay IDLE.
REQ-016 Round-robin SHALL search from index rr_ptr upward, wrapping NUM_REQ-1->0; on each new grant to index g, rr_ptr SHALL become (g+1) mod NUM_REQ.
REQ-017 In BURST, req_ack[g] and fifo_wr_en SHALL be combinationally req_valid[g] AND NOT full; all other req_ack bits 0.
REQ-018 fifo_wr_data SHALL equal req_data slice g while granted, and 0 in IDLE.
REQ-019 fifo_wr_en SHALL never be 1 while full=1 (no overflow generated by this block).
REQ-020 beat_cnt SHALL clear on each new grant and increment on each written beat.
REQ-021 BURST->STALL when full=1 and req_valid[g]=1; STALL->BURST when full=0; grant SHALL be held in STALL.
REQ-022 Grant release SHALL occur on the edge where req_valid[g]=0 (BURST or STALL), or where the MAX_BURST-th beat is written.
REQ-023 On release, if another (or the same) requester is valid and full=0, the new round-robin grant SHALL load on that same edge (no idle bubble); otherwise go to IDLE with grant=0.
REQ-024 A sole requester SHALL be re-granted after MAX_BURST beats via the wrap of REQ-016.
REQ-025 Requester i SHALL hold req_valid and req_data stable until req_ack[i]; deasserting req_valid without ack forfeits the grant per REQ-022.
REQ-026 wr_count SHALL increment by 1 on every cycle with fifo_wr_en=1.

Reset
REQ-027 On rstn=0, asynchronously: state=IDLE, grant=0, rr_ptr=0, beat_cnt=0, wr_count=0; req_ack, fifo_wr_en, fifo_wr_data SHALL be 0 while rstn=0.
REQ-028 Reset asserted mid-burst SHALL abort the burst with no further write; after release, arbitration restarts from requester 0.

Verification
REQ-029 Single requester: req_valid=4'b0001, data 0x10..0x19, full=0 -> 10 beats written in order, grant drops/reloads to 0001 after beats 4 and 8, wr_count=10.
REQ-030 Fairness: req_valid=4'b1111 held, full=0 -> grant order 0001,0010,0100,1000,0001, each 4 beats, no idle cycles between grants.
REQ-031 Backpressure: full=1 for 3 cycles mid-burst of requester 2 -> STALL, fifo_wr_en=0 and req_ack=0 those cycles, grant stays 0100, burst resumes at same beat.
REQ-032 Early release: requester 1 drops req_valid after 2 beats, requester 3 valid -> grant 1000 loads on that edge, rr_ptr=0.
REQ-033 Reset mid-burst: rstn=0 during beat 2 of requester 1 -> grant=0, fifo_wr_en=0 immediately; after rstn=1 with req_valid=4'b0110, first grant=0010.
REQ-034 Wrap: 65537 total writes -> wr_count=1.
